// File: rtl/sum_stage_ctl_pkg.sv
// Shared types for the PE-array sum stage controller.
// Holds the job config layout, the per-beat SumStage/PostProc control words,
// the sequencer state encoding and the default field widths.
package sum_stage_ctl_pkg;

  localparam int PEROW = 8;   // PE rows, width of the row enable mask
  localparam int ACCWD = 8;   // accumulate-count field, holds n_acc-1
  localparam int OUTWD = 10;  // output-count field, holds n_out-1

  // Job config: both counts use a minus-one encoding so all-ones is the max size
  typedef struct packed {
    logic [ACCWD-1:0] acc_m1;
    logic [OUTWD-1:0] out_m1;
    logic [PEROW-1:0] row_en;
  } ss_cfg_t;

  // Partial-sum framing for the current beat
  typedef struct packed {
    logic first;
    logic last;
  } ss_ctl_t;

  // Output-valid marker and index of the output being accumulated
  typedef struct packed {
    logic             ovalid;
    logic [OUTWD-1:0] oidx;
  } pp_ctl_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sum_stage_ctl_if.sv
// Handshake bundle between MultStage, the sum stage sequencer and SumStage.
//   cfg_rdy/cfg_ack/cfg : job config offer and acceptance
//   us_rdy/us_ack       : upstream (MultStage) beat handshake
//   ds_rdy/ds_ack       : downstream (SumStage) beat handshake
//   ssctl/ppctl         : per-beat control words travelling with ds_rdy
// slave  = the sequencer, master = whoever drives the job and the beat stream.
interface sum_stage_ctl_if;
  import sum_stage_ctl_pkg::*;

  logic    cfg_rdy;
  logic    cfg_ack;
  ss_cfg_t cfg;
  logic    us_rdy;
  logic    us_ack;
  logic    ds_rdy;
  logic    ds_ack;
  ss_ctl_t ssctl;
  pp_ctl_t ppctl;

  modport slave (
    input  cfg_rdy, cfg, us_rdy, ds_ack,
    output cfg_ack, us_ack, ds_rdy, ssctl, ppctl
  );

  modport master (
    output cfg_rdy, cfg, us_rdy, ds_ack,
    input  cfg_ack, us_ack, ds_rdy, ssctl, ppctl
  );

endinterface

// File: rtl/sum_stage_ctl_nest_cnt.sv
// Two-level wrap counter: an inner accumulate count that wraps at acc_m1 and
// an outer output count that steps on each inner wrap. Meant to be shared by
// other PE stage controllers that walk an n_acc x n_out iteration space.
//   clk, rst           : clock, synchronous active-high reset
//   clear              : zero both counters (start of a job)
//   inc                : advance by one beat
//   acc_m1, out_m1     : inner/outer terminal values (minus-one encoded)
//   acc_cnt, out_cnt   : current position
//   acc_last, all_last : inner at terminal / both at terminal
module sum_stage_ctl_nest_cnt #(
  parameter int AW = 8,
  parameter int OW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  input  logic [AW-1:0] acc_m1,
  input  logic [OW-1:0] out_m1,
  output logic [AW-1:0] acc_cnt,
  output logic [OW-1:0] out_cnt,
  output logic          acc_last,
  output logic          all_last
);

  assign acc_last = (acc_cnt == acc_m1);
  assign all_last = acc_last && (out_cnt == out_m1);

  // Finishing the whole space returns both counters to zero, so the outer
  // count never steps past out_m1 and the next job starts from a clean state.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
      out_cnt <= '0;
    end else if (clear) begin
      acc_cnt <= '0;
      out_cnt <= '0;
    end else if (inc) begin
      if (all_last) begin
        acc_cnt <= '0;
        out_cnt <= '0;
      end else if (acc_last) begin
        acc_cnt <= '0;
        out_cnt <= out_cnt + 1'b1;
      end else begin
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum_stage_ctl.sv
// Sequencer for the PE-array sum stage. Takes a job config, then gates the
// MultStage->SumStage rdy/ack handshake and frames each beat so SumStage sums
// n_acc partial sums per output for n_out outputs.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_abort      : drop the running job (ignored while idle)
//   bus          : config, upstream and downstream handshakes, ssctl/ppctl
//   o_row_en     : row enable mask latched with the config
//   o_busy       : a job is running
//   o_done       : one-cycle pulse after the final beat of a job transfers
module sum_stage_ctl
  import sum_stage_ctl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_abort,
  sum_stage_ctl_if.slave        bus,
  output logic [PEROW-1:0]      o_row_en,
  output logic                  o_busy,
  output logic                  o_done
);

  state_t           state;
  state_t           state_nxt;
  ss_cfg_t          cfg_q;
  logic             cfg_take;
  logic             xfer;
  logic [ACCWD-1:0] acc_cnt;
  logic [OUTWD-1:0] out_cnt;
  logic             acc_last;
  logic             job_last;

  sum_stage_ctl_nest_cnt #(
    .AW (ACCWD),
    .OW (OUTWD)
  ) u_cnt (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (cfg_take),
    .inc      (xfer),
    .acc_m1   (cfg_q.acc_m1),
    .out_m1   (cfg_q.out_m1),
    .acc_cnt  (acc_cnt),
    .out_cnt  (out_cnt),
    .acc_last (acc_last),
    .all_last (job_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg_q <= '0;
    end else if (cfg_take) begin
      cfg_q <= bus.cfg;
    end
  end

  // xfer is already suppressed on an abort cycle, so an aborted job never
  // raises done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_done <= 1'b0;
    end else begin
      o_done <= xfer && job_last;
    end
  end

  // Abort wins over a beat offered in the same cycle: both handshake outputs
  // are held low so neither side believes the beat moved.
  always_comb begin
    state_nxt   = state;
    bus.cfg_ack = 1'b0;
    bus.ds_rdy  = 1'b0;
    bus.us_ack  = 1'b0;
    cfg_take    = 1'b0;
    xfer        = 1'b0;
    case (state)
      IDLE: begin
        bus.cfg_ack = 1'b1;
        if (bus.cfg_rdy) begin
          cfg_take  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_nxt = IDLE;
        end else begin
          bus.ds_rdy = bus.us_rdy;
          bus.us_ack = bus.ds_ack;
          xfer       = bus.us_rdy && bus.ds_ack;
          if (xfer && job_last) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Framing flags are held low while idle so the stage outputs rest at zero.
  always_comb begin
    bus.ssctl.first  = (state == RUN) && (acc_cnt == '0);
    bus.ssctl.last   = (state == RUN) && acc_last;
    bus.ppctl.ovalid = acc_last && bus.ds_rdy;
    bus.ppctl.oidx   = out_cnt;
  end

  assign o_busy   = (state != IDLE);
  assign o_row_en = cfg_q.row_en;

endmodule

// File: tb/tb_sum_stage_ctl.sv
// Directed self-checking bench for sum_stage_ctl. Expected beat framing is
// pushed to a queue when a job is offered and popped on every downstream
// transfer the DUT makes.
module tb_sum_stage_ctl;
  import sum_stage_ctl_pkg::*;

  typedef struct packed {
    ss_ctl_t ss;
    pp_ctl_t pp;
  } exp_beat_t;

  logic             i_clk;
  logic             i_rst;
  logic             i_abort;
  logic [PEROW-1:0] o_row_en;
  logic             o_busy;
  logic             o_done;

  int n_checks;
  int n_fail;

  exp_beat_t sb_q[$];

  sum_stage_ctl_if bus ();

  sum_stage_ctl dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_abort  (i_abort),
    .bus      (bus.slave),
    .o_row_en (o_row_en),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input int acc_m1, input int out_m1);
    exp_beat_t e;
    for (int o = 0; o <= out_m1; o++) begin
      for (int a = 0; a <= acc_m1; a++) begin
        e.ss.first  = (a == 0);
        e.ss.last   = (a == acc_m1);
        e.pp.ovalid = (a == acc_m1);
        e.pp.oidx   = OUTWD'(o);
        sb_q.push_back(e);
      end
    end
  endtask

  // Offers a job from IDLE and leaves the DUT in RUN, one step after the edge.
  task automatic apply_stimulus(input int acc_m1, input int out_m1, input logic [PEROW-1:0] row);
    push_expect(acc_m1, out_m1);
    bus.cfg_rdy = 1'b1;
    bus.cfg     = '{acc_m1: ACCWD'(acc_m1), out_m1: OUTWD'(out_m1), row_en: row};
    @(negedge i_clk);
    check_output("cfg_ack_idle", 32'(bus.cfg_ack), 32'd1);
    @(posedge i_clk); #1;
    bus.cfg_rdy = 1'b0;
    check_output("busy_after_cfg", 32'(o_busy), 32'd1);
    check_output("row_en_latched", 32'(o_row_en), 32'(row));
  endtask

  // One cycle while RUN: drive handshake inputs, check gating and, on a
  // transfer, the framing against the scoreboard head.
  task automatic one_cycle(input logic ur, input logic da, input logic ab, output logic moved);
    exp_beat_t e;
    bus.us_rdy = ur;
    bus.ds_ack = da;
    i_abort    = ab;
    @(negedge i_clk);
    check_output("ds_rdy_gate", 32'(bus.ds_rdy), 32'(ur && !ab));
    check_output("us_ack_gate", 32'(bus.us_ack), 32'(da && !ab));
    check_output("busy_run", 32'(o_busy), 32'd1);
    check_output("cfg_ack_run", 32'(bus.cfg_ack), 32'd0);
    check_output("done_run", 32'(o_done), 32'd0);
    moved = ur && da && !ab;
    if (moved) begin
      check_output("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_output("ssctl", 32'(bus.ssctl), 32'(e.ss));
        check_output("ppctl", 32'(bus.ppctl), 32'(e.pp));
      end
    end
    @(posedge i_clk); #1;
    i_abort = 1'b0;
  endtask

  // Runs n transfers to the end of a job, then checks the done pulse.
  task automatic run_beats(input int n, input bit stall, input int budget);
    int   got;
    int   cyc;
    logic ur;
    logic da;
    logic moved;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      ur = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      da = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      one_cycle(ur, da, 1'b0, moved);
      if (moved) got++;
      cyc++;
    end
    check_output("transfer_count", 32'(got), 32'(n));
    bus.us_rdy = 1'b0;
    bus.ds_ack = 1'b0;
    @(negedge i_clk);
    check_output("done_pulse", 32'(o_done), 32'd1);
    check_output("busy_after_done", 32'(o_busy), 32'd0);
    check_output("cfg_ack_after_done", 32'(bus.cfg_ack), 32'd1);
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic moved;
    n_checks    = 0;
    n_fail      = 0;
    i_rst       = 1'b1;
    i_abort     = 1'b0;
    bus.cfg_rdy = 1'b0;
    bus.cfg     = '0;
    bus.us_rdy  = 1'b0;
    bus.ds_ack  = 1'b0;

    // Power-up reset
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check_output("rst_busy", 32'(o_busy), 32'd0);
    check_output("rst_cfg_ack", 32'(bus.cfg_ack), 32'd1);
    check_output("rst_done", 32'(o_done), 32'd0);
    check_output("rst_row_en", 32'(o_row_en), 32'd0);
    check_output("rst_ppctl", 32'(bus.ppctl), 32'd0);
    @(posedge i_clk); #1;

    $display("[TB] job acc_m1=3 out_m1=1, no stalls");
    apply_stimulus(3, 1, 8'h0F);
    run_beats(8, 1'b0, 50);
    check_output("done_one_cycle", 32'(o_done), 32'd0);
    check_output("sb_drained_1", 32'(sb_q.size()), 32'd0);

    $display("[TB] job acc_m1=0 out_m1=2");
    apply_stimulus(0, 2, 8'h81);
    run_beats(3, 1'b0, 50);
    check_output("sb_drained_2", 32'(sb_q.size()), 32'd0);

    $display("[TB] job acc_m1=5 out_m1=3 with random stalls");
    apply_stimulus(5, 3, 8'hFF);
    run_beats(24, 1'b1, 1000);
    check_output("sb_drained_3", 32'(sb_q.size()), 32'd0);

    $display("[TB] reset in the middle of a job");
    apply_stimulus(3, 1, 8'h3C);
    one_cycle(1'b1, 1'b1, 1'b0, moved);
    one_cycle(1'b1, 1'b1, 1'b0, moved);
    bus.us_rdy = 1'b1;
    bus.ds_ack = 1'b1;
    i_rst      = 1'b1;
    repeat (2) begin
      @(posedge i_clk); #1;
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    check_output("midrst_busy", 32'(o_busy), 32'd0);
    check_output("midrst_ds_rdy", 32'(bus.ds_rdy), 32'd0);
    check_output("midrst_us_ack", 32'(bus.us_ack), 32'd0);
    check_output("midrst_cfg_ack", 32'(bus.cfg_ack), 32'd1);
    check_output("midrst_ssctl", 32'(bus.ssctl), 32'd0);
    check_output("midrst_row_en", 32'(o_row_en), 32'd0);
    bus.us_rdy = 1'b0;
    bus.ds_ack = 1'b0;
    sb_q.delete();
    @(posedge i_clk); #1;

    $display("[TB] abort together with beat 2");
    apply_stimulus(3, 1, 8'h11);
    one_cycle(1'b1, 1'b1, 1'b0, moved);
    one_cycle(1'b1, 1'b1, 1'b0, moved);
    one_cycle(1'b1, 1'b1, 1'b1, moved);
    bus.us_rdy = 1'b0;
    bus.ds_ack = 1'b0;
    @(negedge i_clk);
    check_output("abort_busy", 32'(o_busy), 32'd0);
    check_output("abort_no_done", 32'(o_done), 32'd0);
    check_output("abort_cfg_ack", 32'(bus.cfg_ack), 32'd1);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output("abort_no_done_late", 32'(o_done), 32'd0);
    sb_q.delete();
    @(posedge i_clk); #1;

    $display("[TB] config held during RUN, back-to-back job");
    i_abort = 1'b1;
    apply_stimulus(1, 1, 8'h5A);
    i_abort = 1'b0;
    push_expect(2, 0);
    bus.cfg_rdy = 1'b1;
    bus.cfg     = '{acc_m1: ACCWD'(2), out_m1: OUTWD'(0), row_en: 8'hC3};
    run_beats(4, 1'b0, 50);
    bus.cfg_rdy = 1'b0;
    check_output("b2b_busy", 32'(o_busy), 32'd1);
    check_output("b2b_row_en", 32'(o_row_en), 32'hC3);
    run_beats(3, 1'b0, 50);
    check_output("sb_drained_4", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
